// File: rtl/mag_sensor_filter.sv
// Multi-channel sensor conditioner: two-flop synchroniser, per-channel debounce,
// rise/fall event pulses and a registered two-pattern direction decode.
module mag_sensor_filter #(
  parameter int                  CHANNELS        = 4,
  parameter int                  DEBOUNCE_CYCLES = 12_500_000,
  parameter int                  CNT_W           = 24,
  parameter bit                  ACTIVE_LOW      = 1'b1,
  parameter logic [CHANNELS-1:0] PAT_FWD         = CHANNELS'(4'b0011),
  parameter logic [CHANNELS-1:0] PAT_REV         = CHANNELS'(4'b1100)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] sens_in,
  output logic [CHANNELS-1:0] sens_clean,
  output logic [CHANNELS-1:0] sens_rise,
  output logic [CHANNELS-1:0] sens_fall,
  output logic                change,
  output logic [1:0]          dir
);

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_FWD  = 2'b01,
    DIR_REV  = 2'b10
  } dir_t;

  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CHANNELS-1:0] IDLE_RAW = {CHANNELS{ACTIVE_LOW}};

  logic [CHANNELS-1:0] s1_reg;
  logic [CHANNELS-1:0] s2_reg;
  logic [CHANNELS-1:0] lvl;
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] clean_reg;
  logic [CHANNELS-1:0] rise_reg;
  logic [CHANNELS-1:0] fall_reg;
  logic                change_reg;
  dir_t                dir_reg;
  dir_t                dir_next;
  logic [CNT_W-1:0]    cnt_reg  [CHANNELS];
  logic [CNT_W-1:0]    cnt_next [CHANNELS];

  // Synchroniser resets to the idle raw level so release does not look like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= IDLE_RAW;
      s2_reg <= IDLE_RAW;
    end else begin
      s1_reg <= sens_in;
      s2_reg <= s1_reg;
    end
  end

  assign lvl = ACTIVE_LOW ? ~s2_reg : s2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign accept[gi]   = (lvl[gi] != clean_reg[gi]) && (cnt_reg[gi] == CNT_MAX);
      // Any sample matching the clean level restarts the stability window.
      assign cnt_next[gi] = ((lvl[gi] == clean_reg[gi]) || accept[gi])
                            ? '0 : cnt_reg[gi] + CNT_W'(1);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg[gi] <= '0;
        end else begin
          cnt_reg[gi] <= cnt_next[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    dir_next = DIR_NONE;
    if (clean_reg == PAT_FWD) begin
      dir_next = DIR_FWD;
    end else if (clean_reg == PAT_REV) begin
      dir_next = DIR_REV;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_reg  <= '0;
      rise_reg   <= '0;
      fall_reg   <= '0;
      change_reg <= 1'b0;
      dir_reg    <= DIR_NONE;
    end else begin
      clean_reg  <= clean_reg ^ accept;
      rise_reg   <= accept & lvl;
      fall_reg   <= accept & ~lvl;
      change_reg <= |accept;
      dir_reg    <= dir_next;
    end
  end

  assign sens_clean = clean_reg;
  assign sens_rise  = rise_reg;
  assign sens_fall  = fall_reg;
  assign change     = change_reg;
  assign dir        = dir_reg;

endmodule

// File: tb/tb_mag_sensor_filter.sv
// Bench for mag_sensor_filter: sliding-window reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mag_sensor_filter;

  localparam int         N    = 4;
  localparam int         D    = 4;
  localparam logic [3:0] FWD  = 4'b0011;
  localparam logic [3:0] REV  = 4'b1100;
  localparam logic [3:0] CONF = 4'b0011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sens_in = 4'hF;

  logic [3:0] clean, rise, fall;
  logic       change;
  logic [1:0] dir;
  logic [3:0] clean2, rise2, fall2;
  logic       change2;
  logic [1:0] dir2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mag_sensor_filter #(
    .CHANNELS(N), .DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(1'b1),
    .PAT_FWD(FWD), .PAT_REV(REV)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .sens_in(sens_in),
    .sens_clean(clean), .sens_rise(rise), .sens_fall(fall),
    .change(change), .dir(dir)
  );

  // Same design with identical patterns: forward must win.
  mag_sensor_filter #(
    .CHANNELS(N), .DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(1'b1),
    .PAT_FWD(CONF), .PAT_REV(CONF)
  ) u_dut_conf (
    .clk(clk), .rst_n(rst_n), .sens_in(sens_in),
    .sens_clean(clean2), .sens_rise(rise2), .sens_fall(fall2),
    .change(change2), .dir(dir2)
  );

  // Model: a channel flips once its last D synchronised samples all disagree
  // with the current clean level. hist[0] is the raw sample from the previous edge.
  logic [3:0] hist [0:D];
  logic [3:0] exp_clean, exp_rise, exp_fall;
  logic       exp_change;
  logic [1:0] exp_dir, exp_dir2;
  logic [3:0] acc;

  function automatic logic [1:0] decode(input logic [3:0] v, input logic [3:0] f,
                                        input logic [3:0] r);
    if (v == f) return 2'b01;
    if (v == r) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    acc = '0;
    for (int c = 0; c < N; c++) begin
      acc[c] = 1'b1;
      for (int j = 1; j <= D; j++) begin
        if ((~hist[j][c]) == exp_clean[c]) acc[c] = 1'b0;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= D; j++) hist[j] <= 4'hF;
      exp_clean  <= '0;
      exp_rise   <= '0;
      exp_fall   <= '0;
      exp_change <= 1'b0;
      exp_dir    <= 2'b00;
      exp_dir2   <= 2'b00;
    end else begin
      for (int j = D; j >= 1; j--) hist[j] <= hist[j-1];
      hist[0]    <= sens_in;
      exp_clean  <= exp_clean ^ acc;
      exp_rise   <= acc & ~exp_clean;
      exp_fall   <= acc & exp_clean;
      exp_change <= |acc;
      exp_dir    <= decode(exp_clean, FWD, REV);
      exp_dir2   <= decode(exp_clean, CONF, CONF);
    end
  end

  task automatic chk(input string nm, input logic [3:0] a, input logic [3:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_clean",  clean,      exp_clean);
    chk("m_rise",   rise,       exp_rise);
    chk("m_fall",   fall,       exp_fall);
    chk("m_change", 4'(change), 4'(exp_change));
    chk("m_dir",    4'(dir),    4'(exp_dir));
    chk("m_clean2", clean2,     exp_clean);
    chk("m_dir2",   4'(dir2),   4'(exp_dir2));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    tick(3);
    chk("rst_clean", clean, 4'b0000);
    chk("rst_rise", rise, 4'b0000);
    chk("rst_change", 4'(change), 4'b0000);
    chk("rst_dir", 4'(dir), 4'b0000);
    rst_n = 1'b1;
    $display("txn reset released");

    sens_in = 4'b1110; tick(5);
    chk("press_early", clean, 4'b0000);
    tick(1);
    chk("press_clean", clean, 4'b0001);
    chk("press_rise", rise, 4'b0001);
    chk("press_change", 4'(change), 4'b0001);
    tick(1);
    chk("press_rise_off", rise, 4'b0000);
    chk("press_dir", 4'(dir), 4'b0000);
    sens_in = 4'hF; tick(8);
    chk("press_release", clean, 4'b0000);
    $display("txn clean press ch0");

    sens_in = 4'b1011; tick(3);
    sens_in = 4'hF;    tick(1);
    sens_in = 4'b1011; tick(3);
    sens_in = 4'hF;    tick(8);
    chk("bounce_clean", clean, 4'b0000);
    $display("txn bounce ch2");

    sens_in = 4'b1100; tick(6);
    chk("fwd_clean", clean, 4'b0011);
    chk("fwd_rise", rise, 4'b0011);
    chk("fwd_change", 4'(change), 4'b0001);
    tick(1);
    chk("fwd_dir", 4'(dir), 4'b0001);
    chk("fwd_change_off", 4'(change), 4'b0000);
    chk("conf_dir", 4'(dir2), 4'b0001);
    sens_in = 4'hF; tick(6);
    chk("fwd_fall", fall, 4'b0011);
    chk("fwd_rel_clean", clean, 4'b0000);
    tick(1);
    chk("fwd_rel_dir", 4'(dir), 4'b0000);
    $display("txn forward decode");

    sens_in = 4'b0011; tick(7);
    chk("rev_clean", clean, 4'b1100);
    chk("rev_dir", 4'(dir), 4'b0010);
    chk("rev_dir2", 4'(dir2), 4'b0000);
    sens_in = 4'b0000; tick(7);
    chk("all_clean", clean, 4'b1111);
    chk("all_dir", 4'(dir), 4'b0000);
    sens_in = 4'hF; tick(8);
    chk("all_release", clean, 4'b0000);
    $display("txn reverse and all-active");

    sens_in = 4'b0111; tick(7);
    chk("pre_rst_clean", clean, 4'b1000);
    sens_in = 4'b0110; tick(4);
    rst_n = 1'b0; #1;
    chk("midrst_clean", clean, 4'b0000);
    chk("midrst_rise", rise, 4'b0000);
    chk("midrst_change", 4'(change), 4'b0000);
    tick(2);
    rst_n = 1'b1; tick(5);
    chk("postrst_early", clean, 4'b0000);
    tick(1);
    chk("postrst_clean", clean, 4'b1001);
    chk("postrst_rise", rise, 4'b1001);
    sens_in = 4'hF; tick(8);
    $display("txn reset mid-count");

    sens_in = 4'b1110; tick(2);
    sens_in = 4'b0110; tick(4);
    chk("stag_rise0", rise, 4'b0001);
    chk("stag_change0", 4'(change), 4'b0001);
    tick(1);
    chk("stag_gap", 4'(change), 4'b0000);
    tick(1);
    chk("stag_rise3", rise, 4'b1000);
    chk("stag_change3", 4'(change), 4'b0001);
    chk("stag_clean", clean, 4'b1001);
    sens_in = 4'hF; tick(8);
    $display("txn staggered ch0/ch3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
